miriscv_csr_file: RTL and testbench
===================================

# miriscv_csr_file

Machine-mode CSR file and trap controller for the miriscv core, sitting beside the execute stage. It services CSR instructions, records trap state on exception or interrupt entry, and restores it on `mret`. It also arbitrates the three machine interrupt sources and runs the 64-bit cycle, instret and hardware-performance counters. It generalises the fixed CSR set with a parametrised HPM counter count, optional vectored `mtvec` mode and per-counter inhibit.

## Interface
- `NUM_HPM`, 2, number of `mhpmcounter3..` counters (0..29); counter i counts `hpm_event_i[i]`
- `VECTORED_EN`, 1, 1 = `mtvec` MODE 01 accepted and vectored interrupt targets generated
- `MTVEC_RESET`, 32'h0, `mtvec` BASE reset value (bits [1:0] ignored)
- `MISA_EXT`, 26'h100, `misa` extension bits; MXL fixed 01
- `HART_ID`, 32'h0, `mhartid` value
- `clk_i` in 1 core clock
- `arstn_i` in 1 asynchronous active-low reset
- `csr_req_i` in 1 CSR instruction valid this cycle
- `csr_op_i` in 2 0 = RW, 1 = RS, 2 = RC (package constants); 3 = illegal
- `csr_addr_i` in 12 CSR address
- `csr_wdata_i` in 32 rs1/uimm operand
- `csr_rdata_o` out 32 old CSR value (combinational)
- `csr_illegal_o` out 1 unimplemented address, bad op, or write to read-only
- `instr_retired_i` in 1 one instruction retired
- `hpm_event_i` in max(NUM_HPM,1) event strobes
- `irq_sw_i`, `irq_timer_i`, `irq_ext_i` in 1 each level interrupt lines
- `irq_req_o` out 1 enabled interrupt pending
- `irq_cause_o` out 5 cause of highest-priority pending interrupt
- `trap_valid_i` in 1 take a trap this cycle
- `trap_is_irq_i` in 1 trap is an interrupt
- `trap_cause_i` in 5 cause code
- `trap_pc_i` in 32 faulting/interrupted PC
- `trap_tval_i` in 32 `mtval` value (ignored for interrupts)
- `mret_i` in 1 execute `mret`
- `trap_target_o` out 32 handler PC (combinational)
- `mepc_o` out 32 return PC for `mret`

## Operation
- Implemented registers:
  - `mstatus` 300: MIE[3], MPIE[7], MPP[12:11] fixed 11.
  - `misa` 301: WARL, writes ignored, no illegal.
  - `mie` 304: bits 3/7/11.
  - `mtvec` 305.
  - `mcountinhibit` 320: bits 0, 2, 3..3+NUM_HPM-1.
  - `mscratch` 340.
  - `mepc` 341: [1:0] = 0.
  - `mcause` 342.
  - `mtval` 343.
  - `mip` 344: read-only bits.
  - `mcycle`/`minstret`/`mhpmcounterN` B00/B02/B03+i and high halves B80/B82/B83+i.
  - `mvendorid`/`marchid`/`mimpid`/`mhartid` F11–F14: read-only, value 0, 0, 0, HART_ID.
- Write value: RW = wdata; RS = old | wdata; RC = old & ~wdata.
- Read-only rule: a write to read-only Fxx or `mip` is illegal. RS/RC with wdata = 0 is not a write. When illegal, there is no state change and `csr_rdata_o` = 0.
- `mtvec` MODE WARL: 00 always accepted; 01 accepted only if VECTORED_EN. Any other value keeps the old MODE. BASE is always written.
- `mip` samples the three irq lines every cycle (registered).
- `irq_req_o` = `mstatus.MIE` & |(`mip` & `mie`).
- Priority: EXT (11) > SW (3) > TIMER (7).
- Trap entry:
  - `mepc` ← pc & ~3
  - `mcause` ← {is_irq, 26'b0, cause}
  - `mtval` ← is_irq ? 0 : tval
  - MPIE ← MIE, MIE ← 0
- `trap_target_o`: BASE<<2; for an interrupt with MODE 01, it is BASE<<2 + 4·cause. Driven from the current (pre-update) `mtvec`.
- `mret`: MIE ← MPIE, MPIE ← 1.
- Counters:
  - Each counter increments by 1 per qualifying cycle/event unless its inhibit bit is set. Counters with an inhibit bit are `mcycle` (bit 0), `minstret` (bit 2) and HPM (bit 3+i).
  - Counters wrap from 2^64−1 to 0.
  - A write to the low or high half replaces that half only; the other half is held and there is no increment that cycle.

## Timing
- Reset values:
  - `mstatus` 0x1880
  - `mtvec` {MTVEC_RESET[31:2], VECTORED_EN ? 01 : 00}
  - all other RW state and counters 0
- Output reset values: `irq_req_o` 0, `irq_cause_o` 0, `mepc_o` 0.
- CSR read is combinational in the request cycle. The write is visible on the next cycle.
- Trap/`mret` updates are visible on the next cycle. `mip` lags the irq lines by 1 cycle, so `irq_req_o` follows an irq edge by 1 cycle.
- Simultaneous events:
  - trap beats `mret` beats CSR write; the losing operation is dropped entirely.
  - a CSR write to a counter beats its increment.
  - a trap does not stop counters.
- A reset mid-operation returns everything to its reset values asynchronously. The first edge after release behaves as cycle 0.

## Structure
- Additions to `miriscv_csr_pkg`:
  - CSR address constants.
  - `CSRRW_OP`/`CSRRS_OP`/`CSRRC_OP`.
  - interrupt/exception cause codes.
  - `mstatus`/`mtvec` field typedefs.
  - reset constants.
- Sub-module `miriscv_csr_counter`:
  - 64-bit counter with inhibit, increment enable, and low/high half write.
  - Instantiated 2+NUM_HPM times.

## Test plan
- Reset, read 300/305/F14 → 0x1880, 0x1 (VECTORED_EN=1), HART_ID; write F11 → `csr_illegal_o` 1, no state change.
- RS 304 wdata 0x888, MIE set, assert `irq_timer_i` and `irq_ext_i` → one cycle later `irq_req_o` 1, `irq_cause_o` 11.
- `mtvec` = 0x1001, trap irq cause 7 at pc 0x206 → `trap_target_o` 0x101C; next cycle `mepc` 0x204, `mcause` 0x80000007, MIE 0, MPIE 1; `mret` → MIE 1.
- Write `mcycle` 0xFFFFFFFF and `mcycleh` 0xFFFFFFFF, then run 1 cycle → wraps to 0, `mcycleh` 0; set `mcountinhibit` bit 0 → value frozen.
- Same cycle: trap exception cause 2 plus `mret` plus CSR write to `mscratch` → only trap state updated, `mscratch` unchanged.
- Write `mtvec` mode 10 → mode stays 01; NUM_HPM=0 build: read B03 → illegal.

Source files
------------

// File: rtl/miriscv_csr_pkg.sv
// miriscv machine-mode CSR definitions.
// Addresses, operation codes, cause codes and field layouts.
package miriscv_csr_pkg;

  localparam logic [1:0] CSRRW_OP = 2'd0;
  localparam logic [1:0] CSRRS_OP = 2'd1;
  localparam logic [1:0] CSRRC_OP = 2'd2;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MCOUNTINH = 12'h320;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MHPM3     = 12'hB03;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;
  localparam logic [11:0] CSR_MIMPID    = 12'hF13;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  localparam logic [4:0] IRQ_M_SW    = 5'd3;
  localparam logic [4:0] IRQ_M_TIMER = 5'd7;
  localparam logic [4:0] IRQ_M_EXT   = 5'd11;
  localparam logic [4:0] EXC_ILLEGAL = 5'd2;

  localparam logic [1:0] MTVEC_DIRECT   = 2'b00;
  localparam logic [1:0] MTVEC_VECTORED = 2'b01;
  localparam logic [1:0] MISA_MXL       = 2'b01;
  localparam logic [1:0] MPP_MACHINE    = 2'b11;

  localparam logic MSTATUS_MIE_RST  = 1'b0;
  localparam logic MSTATUS_MPIE_RST = 1'b1;

  typedef struct packed {
    logic [18:0] rsv3;
    logic [1:0]  mpp;
    logic [2:0]  rsv2;
    logic        mpie;
    logic [2:0]  rsv1;
    logic        mie;
    logic [2:0]  rsv0;
  } mstatus_t;

  typedef struct packed {
    logic [29:0] base;
    logic [1:0]  mode;
  } mtvec_t;

  // {ext, timer, sw} packed into mie/mip bit positions
  function automatic logic [31:0] irq_bits(logic [2:0] v);
    return {20'b0, v[2], 3'b0, v[1], 3'b0, v[0], 3'b0};
  endfunction

endpackage

// File: rtl/miriscv_csr_counter.sv
// 64-bit event counter with inhibit and per-half write.
// A half write wins over the increment in the same cycle.
module miriscv_csr_counter (
  input  logic        clk_i,
  input  logic        arstn_i,
  input  logic        inhibit_i,
  input  logic        inc_i,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] cnt_o
);

  logic [63:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (wr_lo_i)
      cnt_d = {cnt_q[63:32], wdata_i};
    else if (wr_hi_i)
      cnt_d = {wdata_i, cnt_q[31:0]};
    else if (inc_i && !inhibit_i)
      cnt_d = cnt_q + 64'd1;
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/miriscv_csr_file.sv
// miriscv machine-mode CSR file and trap controller.
// Services CSR ops, trap entry/mret, interrupt arbitration, counters.
module miriscv_csr_file
  import miriscv_csr_pkg::*;
#(
  parameter int          NUM_HPM     = 2,
  parameter int          VECTORED_EN = 1,
  parameter logic [31:0] MTVEC_RESET = 32'h0,
  parameter logic [25:0] MISA_EXT    = 26'h100,
  parameter logic [31:0] HART_ID     = 32'h0
) (
  input  logic        clk_i,
  input  logic        arstn_i,
  input  logic        csr_req_i,
  input  logic [1:0]  csr_op_i,
  input  logic [11:0] csr_addr_i,
  input  logic [31:0] csr_wdata_i,
  output logic [31:0] csr_rdata_o,
  output logic        csr_illegal_o,
  input  logic        instr_retired_i,
  input  logic [((NUM_HPM > 0) ? NUM_HPM : 1)-1:0] hpm_event_i,
  input  logic        irq_sw_i,
  input  logic        irq_timer_i,
  input  logic        irq_ext_i,
  output logic        irq_req_o,
  output logic [4:0]  irq_cause_o,
  input  logic        trap_valid_i,
  input  logic        trap_is_irq_i,
  input  logic [4:0]  trap_cause_i,
  input  logic [31:0] trap_pc_i,
  input  logic [31:0] trap_tval_i,
  input  logic        mret_i,
  output logic [31:0] trap_target_o,
  output logic [31:0] mepc_o
);

  localparam int NCNT = 2 + NUM_HPM;
  localparam logic [31:0] MCI_MASK =
    32'h5 | (((32'h1 << NUM_HPM) - 32'h1) << 3);
  localparam mtvec_t MTVEC_RST = {MTVEC_RESET[31:2],
    (VECTORED_EN != 0) ? MTVEC_VECTORED : MTVEC_DIRECT};

  logic        mie_q, mie_d, mpie_q, mpie_d;
  mtvec_t      mtvec_q, mtvec_d;
  logic [2:0]  mien_q, mien_d, mip_q;
  logic [31:0] mcinh_q, mcinh_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] mtval_q, mtval_d;

  logic [63:0] cnt_val [NCNT];
  logic [63:0] cnt_rd;
  logic [31:0] off, cidx, rdata, wval;
  logic        is_cnt, cnt_hi, hit, ro, wr_try, illegal, csr_we;
  mstatus_t    ms;
  logic [2:0]  pend;

  // counter CSRs: offset 0 -> idx 0, offset 2.. -> idx offset-1
  always_comb begin
    off    = {27'd0, csr_addr_i[4:0]};
    cnt_hi = csr_addr_i[7];
    cidx   = (off == 32'd0) ? 32'd0 : off - 32'd1;
    is_cnt = (csr_addr_i[11:8] == 4'hB) && (csr_addr_i[6:5] == 2'b00)
          && ((off == 32'd0) || (off >= 32'd2 && off < 32'(NUM_HPM + 3)));
    cnt_rd = '0;
    for (int k = 0; k < NCNT; k++)
      if (cidx == 32'(k)) cnt_rd = cnt_val[k];
  end

  always_comb begin
    ms      = '0;
    ms.mpp  = MPP_MACHINE;
    ms.mpie = mpie_q;
    ms.mie  = mie_q;
    rdata   = '0;
    hit     = 1'b1;
    ro      = 1'b0;
    unique case (csr_addr_i)
      CSR_MSTATUS:   rdata = ms;
      CSR_MISA:      rdata = {MISA_MXL, 4'b0, MISA_EXT};
      CSR_MIE:       rdata = irq_bits(mien_q);
      CSR_MTVEC:     rdata = mtvec_q;
      CSR_MCOUNTINH: rdata = mcinh_q;
      CSR_MSCRATCH:  rdata = mscratch_q;
      CSR_MEPC:      rdata = mepc_q;
      CSR_MCAUSE:    rdata = mcause_q;
      CSR_MTVAL:     rdata = mtval_q;
      CSR_MIP:       begin rdata = irq_bits(mip_q); ro = 1'b1; end
      CSR_MVENDORID,
      CSR_MARCHID,
      CSR_MIMPID:    ro = 1'b1;
      CSR_MHARTID:   begin rdata = HART_ID; ro = 1'b1; end
      default: begin
        hit   = is_cnt;
        rdata = cnt_hi ? cnt_rd[63:32] : cnt_rd[31:0];
      end
    endcase
  end

  always_comb begin
    wr_try  = (csr_op_i == CSRRW_OP) || (csr_wdata_i != 32'd0);
    illegal = csr_req_i && ((csr_op_i == 2'd3) || !hit || (ro && wr_try));
    csr_we  = csr_req_i && wr_try && !illegal && !trap_valid_i && !mret_i;
    unique case (csr_op_i)
      CSRRW_OP: wval = csr_wdata_i;
      CSRRS_OP: wval = rdata | csr_wdata_i;
      CSRRC_OP: wval = rdata & ~csr_wdata_i;
      default:  wval = rdata;
    endcase
  end

  assign csr_rdata_o   = illegal ? 32'd0 : rdata;
  assign csr_illegal_o = illegal;

  always_comb begin
    mie_d      = mie_q;
    mpie_d     = mpie_q;
    mtvec_d    = mtvec_q;
    mien_d     = mien_q;
    mcinh_d    = mcinh_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    if (trap_valid_i) begin
      mepc_d   = {trap_pc_i[31:2], 2'b00};
      mcause_d = {trap_is_irq_i, 26'b0, trap_cause_i};
      mtval_d  = trap_is_irq_i ? 32'd0 : trap_tval_i;
      mpie_d   = mie_q;
      mie_d    = 1'b0;
    end else if (mret_i) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end else if (csr_we) begin
      unique case (csr_addr_i)
        CSR_MSTATUS: begin mie_d = wval[3]; mpie_d = wval[7]; end
        CSR_MIE:     mien_d = {wval[11], wval[7], wval[3]};
        CSR_MTVEC: begin
          mtvec_d.base = wval[31:2];
          if (wval[1:0] == MTVEC_DIRECT ||
              (wval[1:0] == MTVEC_VECTORED && VECTORED_EN != 0))
            mtvec_d.mode = wval[1:0];
        end
        CSR_MCOUNTINH: mcinh_d    = wval & MCI_MASK;
        CSR_MSCRATCH:  mscratch_d = wval;
        CSR_MEPC:      mepc_d     = {wval[31:2], 2'b00};
        CSR_MCAUSE:    mcause_d   = wval;
        CSR_MTVAL:     mtval_d    = wval;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      mie_q      <= MSTATUS_MIE_RST;
      mpie_q     <= MSTATUS_MPIE_RST;
      mtvec_q    <= MTVEC_RST;
      mien_q     <= '0;
      mip_q      <= '0;
      mcinh_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
    end else begin
      mie_q      <= mie_d;
      mpie_q     <= mpie_d;
      mtvec_q    <= mtvec_d;
      mien_q     <= mien_d;
      mip_q      <= {irq_ext_i, irq_timer_i, irq_sw_i};
      mcinh_q    <= mcinh_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
    end
  end

  // fixed priority: EXT > SW > TIMER
  assign pend      = mip_q & mien_q;
  assign irq_req_o = mie_q && (pend != 3'b000);
  always_comb begin
    if (pend[2])      irq_cause_o = IRQ_M_EXT;
    else if (pend[0]) irq_cause_o = IRQ_M_SW;
    else if (pend[1]) irq_cause_o = IRQ_M_TIMER;
    else              irq_cause_o = 5'd0;
  end

  assign trap_target_o =
    (trap_is_irq_i && mtvec_q.mode == MTVEC_VECTORED)
      ? {mtvec_q.base, 2'b00} + {25'b0, trap_cause_i, 2'b00}
      : {mtvec_q.base, 2'b00};
  assign mepc_o = mepc_q;

  for (genvar k = 0; k < NCNT; k++) begin : g_cnt
    localparam int IB = (k == 0) ? 0 : k + 1;
    logic inc, sel;
    if (k == 0)      begin : g_cyc assign inc = 1'b1;            end
    else if (k == 1) begin : g_ret assign inc = instr_retired_i; end
    else             begin : g_hpm assign inc = hpm_event_i[k-2]; end
    assign sel = csr_we && is_cnt && (cidx == 32'(k));
    miriscv_csr_counter u_cnt (
      .clk_i     (clk_i),
      .arstn_i   (arstn_i),
      .inhibit_i (mcinh_q[IB]),
      .inc_i     (inc),
      .wr_lo_i   (sel && !cnt_hi),
      .wr_hi_i   (sel && cnt_hi),
      .wdata_i   (wval),
      .cnt_o     (cnt_val[k])
    );
  end

endmodule

// File: tb/tb_miriscv_csr_file.sv
// Directed bench for miriscv_csr_file.
// Second instance built with NUM_HPM=0 for the missing-counter case.
module tb_miriscv_csr_file;
  import miriscv_csr_pkg::*;

  logic        clk = 1'b0;
  logic        arstn;
  logic        csr_req;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata, csr_rdata0;
  logic        csr_illegal, csr_illegal0;
  logic        instr_ret;
  logic [1:0]  hpm_ev;
  logic        irq_sw, irq_tmr, irq_ext;
  logic        irq_req, irq_req0;
  logic [4:0]  irq_cause, irq_cause0;
  logic        trap_valid, trap_irq, mret;
  logic [4:0]  trap_cause;
  logic [31:0] trap_pc, trap_tval;
  logic [31:0] trap_tgt, trap_tgt0, mepc, mepc0;

  int n_chk = 0;
  int n_err = 0;

  always #50 clk = ~clk;

  miriscv_csr_file #(
    .NUM_HPM(2), .VECTORED_EN(1), .MTVEC_RESET(32'h0),
    .MISA_EXT(26'h100), .HART_ID(32'hA5)
  ) u_dut (
    .clk_i(clk), .arstn_i(arstn),
    .csr_req_i(csr_req), .csr_op_i(csr_op),
    .csr_addr_i(csr_addr), .csr_wdata_i(csr_wdata),
    .csr_rdata_o(csr_rdata), .csr_illegal_o(csr_illegal),
    .instr_retired_i(instr_ret), .hpm_event_i(hpm_ev),
    .irq_sw_i(irq_sw), .irq_timer_i(irq_tmr), .irq_ext_i(irq_ext),
    .irq_req_o(irq_req), .irq_cause_o(irq_cause),
    .trap_valid_i(trap_valid), .trap_is_irq_i(trap_irq),
    .trap_cause_i(trap_cause), .trap_pc_i(trap_pc),
    .trap_tval_i(trap_tval), .mret_i(mret),
    .trap_target_o(trap_tgt), .mepc_o(mepc)
  );

  miriscv_csr_file #(.NUM_HPM(0)) u_dut0 (
    .clk_i(clk), .arstn_i(arstn),
    .csr_req_i(csr_req), .csr_op_i(csr_op),
    .csr_addr_i(csr_addr), .csr_wdata_i(csr_wdata),
    .csr_rdata_o(csr_rdata0), .csr_illegal_o(csr_illegal0),
    .instr_retired_i(instr_ret), .hpm_event_i(hpm_ev[0:0]),
    .irq_sw_i(irq_sw), .irq_timer_i(irq_tmr), .irq_ext_i(irq_ext),
    .irq_req_o(irq_req0), .irq_cause_o(irq_cause0),
    .trap_valid_i(trap_valid), .trap_is_irq_i(trap_irq),
    .trap_cause_i(trap_cause), .trap_pc_i(trap_pc),
    .trap_tval_i(trap_tval), .mret_i(mret),
    .trap_target_o(trap_tgt0), .mepc_o(mepc0)
  );

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_go(input logic [1:0] op, input logic [11:0] a,
                        input logic [31:0] wd, input bit step,
                        output logic [31:0] rd, output logic ill);
    csr_req = 1'b1; csr_op = op; csr_addr = a; csr_wdata = wd;
    #1;
    rd  = csr_rdata;
    ill = csr_illegal;
    if (step) tick();
    csr_req = 1'b0; csr_wdata = '0;
  endtask

  task automatic rd_chk(input string tag, input logic [11:0] a,
                        input logic [31:0] exp);
    logic [31:0] r;
    logic i;
    csr_go(CSRRS_OP, a, 32'h0, 1'b0, r, i);
    check(tag, r, exp);
  endtask

  task automatic wr(input logic [1:0] op, input logic [11:0] a,
                    input logic [31:0] wd);
    logic [31:0] r;
    logic i;
    csr_go(op, a, wd, 1'b1, r, i);
  endtask

  initial begin
    logic [31:0] r;
    logic        il;
    arstn = 1'b0; csr_req = 1'b0; csr_op = '0; csr_addr = '0;
    csr_wdata = '0; instr_ret = 1'b0; hpm_ev = '0;
    irq_sw = 1'b0; irq_tmr = 1'b0; irq_ext = 1'b0;
    trap_valid = 1'b0; trap_irq = 1'b0; trap_cause = '0;
    trap_pc = '0; trap_tval = '0; mret = 1'b0;
    #120 arstn = 1'b1;
    tick();

    check("rst_irq_req", irq_req, 0);
    check("rst_irq_cause", irq_cause, 0);
    check("rst_mepc", mepc, 0);
    rd_chk("rst_mstatus", CSR_MSTATUS, 32'h1880);
    rd_chk("rst_mtvec", CSR_MTVEC, 32'h1);
    rd_chk("mhartid", CSR_MHARTID, 32'hA5);
    rd_chk("misa", CSR_MISA, 32'h4000_0100);
    rd_chk("mvendorid", CSR_MVENDORID, 32'h0);

    csr_go(CSRRW_OP, CSR_MVENDORID, 32'h1, 1'b1, r, il);
    check("ro_wr_ill", il, 1);
    check("ro_wr_rdata", r, 0);
    csr_go(CSRRS_OP, CSR_MHARTID, 32'h0, 1'b0, r, il);
    check("ro_rs0_ill", il, 0);
    csr_go(CSRRC_OP, CSR_MIP, 32'h8, 1'b0, r, il);
    check("mip_rc_ill", il, 1);
    csr_go(2'd3, CSR_MSCRATCH, 32'h0, 1'b0, r, il);
    check("badop_ill", il, 1);
    csr_go(CSRRS_OP, 12'h7C0, 32'h0, 1'b0, r, il);
    check("unimpl_ill", il, 1);
    csr_go(CSRRW_OP, CSR_MISA, 32'h0, 1'b1, r, il);
    check("misa_wr_ill", il, 0);
    rd_chk("misa_kept", CSR_MISA, 32'h4000_0100);

    wr(CSRRW_OP, CSR_MSCRATCH, 32'hDEAD_BEEF);
    rd_chk("mscratch_rw", CSR_MSCRATCH, 32'hDEAD_BEEF);
    csr_go(CSRRC_OP, CSR_MSCRATCH, 32'h0000_FFFF, 1'b1, r, il);
    check("mscratch_rc_old", r, 32'hDEAD_BEEF);
    rd_chk("mscratch_rc", CSR_MSCRATCH, 32'hDEAD_0000);
    wr(CSRRS_OP, CSR_MSCRATCH, 32'h1);
    rd_chk("mscratch_rs", CSR_MSCRATCH, 32'hDEAD_0001);

    wr(CSRRS_OP, CSR_MIE, 32'h888);
    wr(CSRRS_OP, CSR_MSTATUS, 32'h8);
    rd_chk("mie", CSR_MIE, 32'h888);
    rd_chk("mstatus_mie", CSR_MSTATUS, 32'h1888);
    irq_tmr = 1'b1; irq_ext = 1'b1;
    #1 check("irq_lag", irq_req, 0);
    tick();
    check("irq_req", irq_req, 1);
    check("irq_cause_ext", irq_cause, 11);
    rd_chk("mip", CSR_MIP, 32'h880);
    irq_ext = 1'b0; irq_sw = 1'b1;
    tick();
    check("irq_cause_sw", irq_cause, 3);
    irq_sw = 1'b0;
    tick();
    check("irq_cause_tmr", irq_cause, 7);
    irq_tmr = 1'b0;
    tick();
    check("irq_idle", irq_req, 0);

    wr(CSRRW_OP, CSR_MTVEC, 32'h1001);
    rd_chk("mtvec_vec", CSR_MTVEC, 32'h1001);
    trap_irq = 1'b0; trap_cause = EXC_ILLEGAL;
    #1 check("tgt_exc", trap_tgt, 32'h1000);
    trap_valid = 1'b1; trap_irq = 1'b1; trap_cause = IRQ_M_TIMER;
    trap_pc = 32'h206; trap_tval = 32'h123;
    #1 check("tgt_irq", trap_tgt, 32'h101C);
    tick();
    trap_valid = 1'b0;
    check("mepc_o", mepc, 32'h204);
    rd_chk("mepc", CSR_MEPC, 32'h204);
    rd_chk("mcause_irq", CSR_MCAUSE, 32'h8000_0007);
    rd_chk("mtval_irq", CSR_MTVAL, 32'h0);
    rd_chk("mstatus_trap", CSR_MSTATUS, 32'h1880);
    mret = 1'b1;
    tick();
    mret = 1'b0;
    rd_chk("mstatus_mret", CSR_MSTATUS, 32'h1888);

    trap_valid = 1'b1; trap_irq = 1'b0; trap_cause = EXC_ILLEGAL;
    trap_pc = 32'h333; trap_tval = 32'hBAD; mret = 1'b1;
    wr(CSRRW_OP, CSR_MSCRATCH, 32'h1111_1111);
    trap_valid = 1'b0; mret = 1'b0;
    rd_chk("race_mscratch", CSR_MSCRATCH, 32'hDEAD_0001);
    rd_chk("race_mepc", CSR_MEPC, 32'h330);
    rd_chk("race_mcause", CSR_MCAUSE, 32'h2);
    rd_chk("race_mtval", CSR_MTVAL, 32'hBAD);
    rd_chk("race_mstatus", CSR_MSTATUS, 32'h1880);
    mret = 1'b1;
    wr(CSRRW_OP, CSR_MSTATUS, 32'h0);
    mret = 1'b0;
    rd_chk("mret_vs_wr", CSR_MSTATUS, 32'h1888);

    wr(CSRRW_OP, CSR_MTVEC, 32'h2002);
    rd_chk("mtvec_mode10", CSR_MTVEC, 32'h2001);
    wr(CSRRW_OP, CSR_MTVEC, 32'h3000);
    rd_chk("mtvec_mode00", CSR_MTVEC, 32'h3000);

    instr_ret = 1'b1;
    tick(); tick(); tick();
    instr_ret = 1'b0;
    rd_chk("minstret", CSR_MINSTRET, 32'd3);
    instr_ret = 1'b1;
    wr(CSRRW_OP, CSR_MINSTRETH, 32'h5);
    instr_ret = 1'b0;
    rd_chk("minstret_hold", CSR_MINSTRET, 32'd3);
    rd_chk("minstreth", CSR_MINSTRETH, 32'd5);

    hpm_ev = 2'b01;
    tick(); tick();
    hpm_ev = 2'b00;
    rd_chk("hpm3", CSR_MHPM3, 32'd2);
    rd_chk("hpm4", 12'hB04, 32'd0);
    wr(CSRRS_OP, CSR_MCOUNTINH, 32'h8);
    hpm_ev = 2'b11;
    tick(); tick();
    hpm_ev = 2'b00;
    rd_chk("hpm3_inh", CSR_MHPM3, 32'd2);
    rd_chk("hpm4_cnt", 12'hB04, 32'd2);

    wr(CSRRW_OP, CSR_MCYCLE, 32'hFFFF_FFFF);
    wr(CSRRW_OP, CSR_MCYCLEH, 32'hFFFF_FFFF);
    rd_chk("mcycle_max", CSR_MCYCLE, 32'hFFFF_FFFF);
    rd_chk("mcycleh_max", CSR_MCYCLEH, 32'hFFFF_FFFF);
    tick();
    rd_chk("mcycle_wrap", CSR_MCYCLE, 32'h0);
    rd_chk("mcycleh_wrap", CSR_MCYCLEH, 32'h0);
    wr(CSRRS_OP, CSR_MCOUNTINH, 32'h1);
    rd_chk("mcycle_inh0", CSR_MCYCLE, 32'h1);
    tick(); tick();
    rd_chk("mcycle_inh1", CSR_MCYCLE, 32'h1);
    wr(CSRRW_OP, CSR_MCOUNTINH, 32'hFFFF_FFFF);
    rd_chk("mcountinh_mask", CSR_MCOUNTINH, 32'h1D);

    csr_req = 1'b1; csr_op = CSRRS_OP; csr_addr = CSR_MHPM3;
    csr_wdata = '0;
    #1;
    check("hpm0_b03_ill", csr_illegal0, 1);
    check("hpm2_b03_ok", csr_illegal, 0);
    csr_addr = CSR_MINSTRET;
    #1 check("hpm0_b02_ok", csr_illegal0, 0);
    csr_req = 1'b0;

    arstn = 1'b0;
    #1;
    check("arst_mepc", mepc, 0);
    rd_chk("arst_mscratch", CSR_MSCRATCH, 32'h0);
    rd_chk("arst_mstatus", CSR_MSTATUS, 32'h1880);
    rd_chk("arst_mtvec", CSR_MTVEC, 32'h1);
    rd_chk("arst_minstreth", CSR_MINSTRETH, 32'h0);
    #20 arstn = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
